// File: rtl/mul_fu_issuer.sv
// Issue controller for the sequential 33x33 multiplier: extends RV32M operands,
// drives start/complete, and holds the selected product half on the CDB.
module mul_fu_issuer #(
  parameter int ROB_IDX_W  = 5,
  parameter int PREG_IDX_W = 6,
  parameter int MIN_WAIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [1:0]            issue_op,
  input  logic [31:0]           issue_rs1,
  input  logic [31:0]           issue_rs2,
  input  logic [PREG_IDX_W-1:0] issue_pd,
  input  logic [ROB_IDX_W-1:0]  issue_rob,
  output logic                  mult_start,
  output logic [32:0]           mult_a,
  output logic [32:0]           mult_b,
  input  logic                  mult_complete,
  input  logic [65:0]           mult_product,
  output logic                  cdb_valid,
  input  logic                  cdb_ready,
  output logic [31:0]           cdb_data,
  output logic [PREG_IDX_W-1:0] cdb_pd,
  output logic [ROB_IDX_W-1:0]  cdb_rob
);

  localparam int CW = (MIN_WAIT < 1) ? 1 : $clog2(MIN_WAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MIN_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_inc;
  logic [1:0]            op_q;
  logic [PREG_IDX_W-1:0] pd_q;
  logic [ROB_IDX_W-1:0]  rob_q;
  logic                  accept, capture, trust;
  logic [32:0]           ext_a, ext_b;
  logic [31:0]           res;
  logic                  unused_hi;

  assign unused_hi = ^mult_product[65:64];

  // Only MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
  assign ext_a = {issue_rs1[31] & (issue_op != 2'b11), issue_rs1};
  assign ext_b = {issue_rs2[31] & ~issue_op[1], issue_rs2};

  assign res = (op_q == 2'b00) ? mult_product[31:0]
                               : mult_product[63:32];

  // cnt_inc counts the current BUSY cycle, so complete is trusted
  // from the MIN_WAIT-th BUSY cycle onward.
  assign cnt_inc = (cnt >= CMAX) ? cnt : cnt + CW'(1);
  assign trust   = (cnt_inc >= CMAX);

  assign mult_start = (state == START);
  assign cdb_valid  = (state == DONE);

  always_comb begin
    state_nx    = state;
    issue_ready = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          accept   = 1'b1;
          state_nx = START;
        end
      end
      START: state_nx = BUSY;
      BUSY: begin
        if (trust && mult_complete) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        issue_ready = cdb_ready;
        if (cdb_ready) begin
          if (issue_valid) begin
            accept   = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      accept   = 1'b0;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      pd_q     <= '0;
      rob_q    <= '0;
      mult_a   <= '0;
      mult_b   <= '0;
      cdb_data <= '0;
      cdb_pd   <= '0;
      cdb_rob  <= '0;
    end else begin
      state <= state_nx;
      if (state == START) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt_inc;
      end
      if (accept) begin
        op_q   <= issue_op;
        pd_q   <= issue_pd;
        rob_q  <= issue_rob;
        mult_a <= ext_a;
        mult_b <= ext_b;
      end
      if (capture) begin
        cdb_data <= res;
        cdb_pd   <= pd_q;
        cdb_rob  <= rob_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_fu_issuer.sv
// Directed bench for mul_fu_issuer with a latency-programmable
// behavioural multiplier whose complete stays high between operations.
module tb_mul_fu_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [5:0]  issue_pd;
  logic [4:0]  issue_rob;
  logic        mult_start;
  logic [32:0] mult_a;
  logic [32:0] mult_b;
  logic        mult_complete;
  logic [65:0] mult_product;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_pd;
  logic [4:0]  cdb_rob;

  int checks = 0;
  int errors = 0;

  logic        stale_hi = 1'b0;
  int          mlat = 0;
  int          mcnt = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b1;
  logic [65:0] m_prod = '0;

  always #5 clk = ~clk;

  mul_fu_issuer #(
    .ROB_IDX_W (5),
    .PREG_IDX_W(6),
    .MIN_WAIT  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_pd     (issue_pd),
    .issue_rob    (issue_rob),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_complete(mult_complete),
    .mult_product (mult_product),
    .cdb_valid    (cdb_valid),
    .cdb_ready    (cdb_ready),
    .cdb_data     (cdb_data),
    .cdb_pd       (cdb_pd),
    .cdb_rob      (cdb_rob)
  );

  // Multiplier model: complete drops on start, rises mlat+1 cycles later.
  always @(posedge clk) begin
    if (mult_start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      mcnt   <= mlat;
      m_prod <= {{33{mult_a[32]}}, mult_a} * {{33{mult_b[32]}}, mult_b};
    end else if (m_busy) begin
      if (mcnt == 0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  assign mult_complete = stale_hi | m_done;
  assign mult_product  = m_prod;

  task automatic chk(input string tag, input logic [65:0] obs,
                     input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] pd, input logic [4:0] rob,
                        input logic [32:0] ea, input logic [32:0] eb,
                        input logic [31:0] ed, input int elat);
    int n;
    issue_op    = op;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_pd    = pd;
    issue_rob   = rob;
    issue_valid = 1'b1;
    #1 chk({tag, "_rdy"}, issue_ready, 1);
    @(negedge clk);
    issue_valid = 1'b0;
    chk({tag, "_start"}, mult_start, 1);
    chk({tag, "_a"}, mult_a, ea);
    chk({tag, "_b"}, mult_b, eb);
    @(negedge clk);
    n = 2;
    chk({tag, "_start_lo"}, mult_start, 0);
    while (!cdb_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_data"}, cdb_data, ed);
    chk({tag, "_pd"}, cdb_pd, pd);
    chk({tag, "_rob"}, cdb_rob, rob);
    cdb_ready = 1'b1;
    #1 chk({tag, "_rdy_done"}, issue_ready, 1);
    @(negedge clk);
    cdb_ready = 1'b0;
    chk({tag, "_retired"}, cdb_valid, 0);
  endtask

  initial begin
    int   n;
    logic seen;
    rst         = 1'b1;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = 2'b00;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_pd    = '0;
    issue_rob   = '0;
    cdb_ready   = 1'b0;
    #12;
    chk("rst_rdy", issue_ready, 1);
    chk("rst_start", mult_start, 0);
    chk("rst_valid", cdb_valid, 0);
    chk("rst_a", mult_a, 0);
    chk("rst_b", mult_b, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_pd", cdb_pd, 0);
    chk("rst_rob", cdb_rob, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    mlat = 0;
    run_op("mul", 2'b00, 32'd7, 32'hFFFFFFFD, 6'd9, 5'd3,
           33'h0_00000007, 33'h1_FFFFFFFD, 32'hFFFFFFEB, 4);
    mlat = 3;
    run_op("mulh", 2'b01, 32'h80000000, 32'h80000000, 6'd10, 5'd4,
           33'h1_80000000, 33'h1_80000000, 32'h40000000, 7);
    mlat = 1;
    run_op("mulhu", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 5'd5,
           33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 32'hFFFFFFFE, 5);
    mlat = 0;
    run_op("mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd12, 5'd6,
           33'h1_FFFFFFFF, 33'h0_FFFFFFFF, 32'hFFFFFFFF, 4);

    stale_hi = 1'b1;
    mlat     = 10;
    run_op("stale", 2'b00, 32'd5, 32'd6, 6'd13, 5'd7,
           33'h0_00000005, 33'h0_00000006, 32'd30, 4);
    stale_hi = 1'b0;

    // Backpressure then back-to-back handoff
    mlat        = 0;
    issue_op    = 2'b00;
    issue_rs1   = 32'd100;
    issue_rs2   = 32'd3;
    issue_pd    = 6'd20;
    issue_rob   = 5'd7;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    n = 1;
    while (!cdb_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait", cdb_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", cdb_valid, 1);
      chk("bp_data", cdb_data, 32'd300);
      chk("bp_pd", cdb_pd, 6'd20);
      chk("bp_rdy", issue_ready, 0);
      @(negedge clk);
    end
    issue_rs1   = 32'd2;
    issue_rs2   = 32'd21;
    issue_pd    = 6'd21;
    issue_rob   = 5'd8;
    issue_valid = 1'b1;
    cdb_ready   = 1'b1;
    #1 chk("b2b_rdy", issue_ready, 1);
    @(negedge clk);
    issue_valid = 1'b0;
    cdb_ready   = 1'b0;
    chk("b2b_start", mult_start, 1);
    chk("b2b_valid_lo", cdb_valid, 0);
    n = 1;
    while (!cdb_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat", n, 4);
    chk("b2b_data", cdb_data, 32'd42);
    chk("b2b_pd", cdb_pd, 6'd21);
    chk("b2b_rob", cdb_rob, 5'd8);
    cdb_ready = 1'b1;
    @(negedge clk);
    cdb_ready = 1'b0;

    // Flush in BUSY
    mlat        = 5;
    issue_rs1   = 32'd3;
    issue_rs2   = 32'd3;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fb_valid", cdb_valid, 0);
    chk("fb_rdy", issue_ready, 1);
    chk("fb_start", mult_start, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | cdb_valid;
    end
    chk("fb_no_cdb", seen, 0);

    // Flush in DONE with grant and a same-cycle issue
    mlat        = 0;
    issue_rs1   = 32'd9;
    issue_rs2   = 32'd9;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    n = 1;
    while (!cdb_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("fd_wait", cdb_valid, 1);
    flush       = 1'b1;
    cdb_ready   = 1'b1;
    issue_valid = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    cdb_ready   = 1'b0;
    issue_valid = 1'b0;
    chk("fd_valid", cdb_valid, 0);
    chk("fd_rdy", issue_ready, 1);
    chk("fd_start", mult_start, 0);
    @(negedge clk);
    chk("fd_start2", mult_start, 0);
    run_op("mul34", 2'b00, 32'd3, 32'd4, 6'd30, 5'd9,
           33'h0_00000003, 33'h0_00000004, 32'd12, 4);

    // Asynchronous reset in BUSY
    mlat        = 5;
    issue_rs1   = 32'd11;
    issue_rs2   = 32'd11;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_rdy", issue_ready, 1);
    chk("ar_start", mult_start, 0);
    chk("ar_valid", cdb_valid, 0);
    chk("ar_a", mult_a, 0);
    chk("ar_b", mult_b, 0);
    chk("ar_data", cdb_data, 0);
    chk("ar_pd", cdb_pd, 0);
    chk("ar_rob", cdb_rob, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | cdb_valid;
    end
    chk("ar_no_cdb", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_fu_issuer.md
Name: mul_fu_issuer

Overview:
- Initiator-side controller for the sequential 33x33 signed multiplier (start/complete handshake, 66-bit product).
- Accepts one RV32M multiply (MUL/MULH/MULHSU/MULHU) from the multiply reservation station.
- Sign- or zero-extends the operands to 33 bits, pulses start, waits for complete, selects the 32-bit result half, and holds it on the CDB with valid/ready until accepted.
- One operation in flight; supports flush.

Parameters:
- ROB_IDX_W, 5, width of ROB index tag.
- PREG_IDX_W, 6, width of physical destination register tag.
- MIN_WAIT, 2, number of BUSY cycles before mult_complete is trusted (masks the stale-high complete from the previous operation).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of any in-flight or pending op.
- issue_valid  in  1  RS presents an op.
- issue_ready  out  1  controller accepts the op this cycle.
- issue_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- issue_rs1  in  32  operand A.
- issue_rs2  in  32  operand B.
- issue_pd  in  PREG_IDX_W  destination physical register.
- issue_rob  in  ROB_IDX_W  ROB index.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_a  out  33  extended operand A, stable from START until the op leaves BUSY.
- mult_b  out  33  extended operand B, same stability rule.
- mult_complete  in  1  multiplier done.
- mult_product  in  66  multiplier product.
- cdb_valid  out  1  result valid.
- cdb_ready  in  1  CDB arbiter grant.
- cdb_data  out  32  result.
- cdb_pd  out  PREG_IDX_W  tag.
- cdb_rob  out  ROB_IDX_W  tag.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, wait counter=0.
  - issue_ready=1, mult_start=0, cdb_valid=0.
  - mult_a, mult_b, cdb_data, cdb_pd, cdb_rob = 0.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - issue_ready=1.
  - A handshake (issue_valid & issue_ready & !flush) latches op, pd, rob and the extended operands, then moves to START.
- Operand extension:
  - MUL, MULH: a = {rs1[31], rs1}, b = {rs2[31], rs2}.
  - MULHSU: a = {rs1[31], rs1}, b = {1'b0, rs2}.
  - MULHU: a = {1'b0, rs1}, b = {1'b0, rs2}.
- START:
  - mult_start=1 for exactly this one cycle.
  - Clear the counter; next state is BUSY.
- BUSY:
  - mult_start=0; the counter increments and saturates at MIN_WAIT.
  - When counter >= MIN_WAIT and mult_complete=1: capture the result, move to DONE.
  - Any mult_complete seen earlier is ignored.
- Result select: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32]. product[65:64] is ignored.
- DONE:
  - cdb_valid=1; cdb_data, cdb_pd and cdb_rob are held stable until cdb_ready=1.
  - issue_ready = cdb_ready, so a back-to-back handoff is allowed.
  - On cdb_ready with an accepted new issue, go to START; on cdb_ready with no issue, go to IDLE.
- issue_ready is 0 in START and BUSY, and 0 in DONE while cdb_ready=0.
- Latency: issue handshake at cycle 0 → mult_start at cycle 1 → cdb_valid no earlier than cycle 2+MIN_WAIT, then multiplier-dependent.
- flush (any state):
  - Next state is IDLE and cdb_valid drops the next cycle; a same-cycle issue is rejected.
  - A result in DONE is discarded even if cdb_ready=1 in the same cycle.
  - A multiplier left running is not stopped; the next start restarts it, and the MIN_WAIT masking covers its stale complete.
- Reset mid-operation returns immediately to the reset values; no result is emitted.
- mult_start is never asserted outside START.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → mult_a=0x0_00000007, mult_b=0x1_FFFFFFFD; one mult_start pulse; cdb_data=0xFFFFFFEB with the issued pd/rob.
- MULH 0x80000000 x 0x80000000 → cdb_data=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFF.
- Stale complete: mult_complete held high throughout → no capture before MIN_WAIT BUSY cycles; cdb_valid first asserts exactly 2+MIN_WAIT cycles after the issue handshake.
- Backpressure: cdb_ready low for 5 cycles → cdb_valid and data stable, issue_ready=0; then cdb_ready=1 with issue_valid=1 → new op accepted, mult_start on the next cycle, no idle bubble.
- Flush in BUSY, then flush in DONE with cdb_ready=1 → no CDB transfer; IDLE next cycle; the following MUL 3x4 returns 12.
- Assert rst during BUSY → all outputs 0 and issue_ready=1 immediately (asynchronous); no cdb_valid afterward.
